// File: rtl/mcdf_rd_arbiter.sv
// Round-robin read arbiter: grants one MCDF channel FIFO at a time for a fixed-length
// packet and streams its head words to the formatter. Optional macro MCDF_ARB_CH_MASK_EN adds cfg_ch_en.
module mcdf_rd_arbiter #(
  parameter int CH_NUM        = 3,
  parameter int FIFO_PTR_WIDE = 3,
  parameter int PKT_LEN       = 4,
  parameter int DATA_W        = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CH_NUM-1:0]                    ch_empty,
  input  logic [CH_NUM*(FIFO_PTR_WIDE+1)-1:0]  ch_level,
  input  logic [CH_NUM*DATA_W-1:0]             ch_data,
`ifdef MCDF_ARB_CH_MASK_EN
  input  logic [CH_NUM-1:0]                    cfg_ch_en,
`endif
  output logic [CH_NUM-1:0]                    ch_rd_en,
  input  logic                                 fmt_ready,
  output logic                                 fmt_valid,
  output logic [DATA_W-1:0]                    fmt_data,
  output logic [2:0]                           fmt_ch_id,
  output logic                                 fmt_start,
  output logic                                 fmt_end,
  output logic                                 busy
);

  localparam int LVL_W = FIFO_PTR_WIDE + 1;
  localparam logic [LVL_W-1:0] PKT_LEN_L = LVL_W'(PKT_LEN);
  localparam logic [LVL_W-1:0] LAST_BEAT = LVL_W'(PKT_LEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [LVL_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [7:0]        elig;
  logic [7:0]        empty8;
  logic [DATA_W-1:0] head_data;
  logic              head_vld;
  logic              xfer;
  logic              win_found;
  logic [2:0]        win_idx;
  logic [2:0]        scan;

  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (v == 3'(CH_NUM - 1)) ? 3'd0 : v + 3'd1;
  endfunction

  always_comb begin
    elig = '0;
    for (int i = 0; i < CH_NUM; i++) begin
`ifdef MCDF_ARB_CH_MASK_EN
      elig[i] = (ch_level[i*LVL_W +: LVL_W] >= PKT_LEN_L) && cfg_ch_en[i];
`else
      elig[i] = (ch_level[i*LVL_W +: LVL_W] >= PKT_LEN_L);
`endif
    end
  end

  // Scan starts at rr_ptr and wraps; first eligible channel wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    scan      = rr_ptr_q;
    for (int k = 0; k < CH_NUM; k++) begin
      if (!win_found && elig[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
      scan = wrap_inc(scan);
    end
  end

  always_comb begin
    empty8               = '0;
    empty8[CH_NUM-1:0]   = ch_empty;
    head_vld             = !empty8[gnt_q];
    head_data            = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (gnt_q == 3'(i)) head_data = ch_data[i*DATA_W +: DATA_W];
    end
  end

  assign xfer = (state_q == SEND) && head_vld && fmt_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d      = win_idx;
          rr_ptr_d   = wrap_inc(win_idx);
          beat_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        // An empty granted FIFO simply holds the packet until data reappears.
        if (xfer) begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while rst is high so an aborted beat is never popped.
  always_comb begin
    fmt_valid = 1'b0;
    fmt_start = 1'b0;
    fmt_end   = 1'b0;
    busy      = 1'b0;
    fmt_data  = '0;
    fmt_ch_id = '0;
    ch_rd_en  = '0;
    if (!rst) begin
      fmt_data  = head_data;
      fmt_ch_id = gnt_q;
      if (state_q == SEND) begin
        busy      = 1'b1;
        fmt_valid = head_vld;
        fmt_start = head_vld && (beat_cnt_q == '0);
        fmt_end   = head_vld && (beat_cnt_q == LAST_BEAT);
        for (int i = 0; i < CH_NUM; i++) begin
          ch_rd_en[i] = xfer && (gnt_q == 3'(i));
        end
      end
    end
  end

endmodule

// File: tb/tb_mcdf_rd_arbiter.sv
// Directed bench for mcdf_rd_arbiter: FIFO model per channel plus a beat scoreboard.
module tb_mcdf_rd_arbiter;

  localparam int CH_NUM  = 3;
  localparam int LVL_W   = 4;
  localparam int PKT_LEN = 4;
  localparam int DATA_W  = 32;

  typedef struct packed {
    logic [2:0]  ch;
    logic [31:0] data;
    logic        st;
    logic        en;
  } beat_t;

  logic                       clk;
  logic                       rst;
  logic [CH_NUM-1:0]          ch_empty;
  logic [CH_NUM*LVL_W-1:0]    ch_level;
  logic [CH_NUM*DATA_W-1:0]   ch_data;
  logic [CH_NUM-1:0]          ch_rd_en;
  logic                       fmt_ready;
  logic                       fmt_valid;
  logic [DATA_W-1:0]          fmt_data;
  logic [2:0]                 fmt_ch_id;
  logic                       fmt_start;
  logic                       fmt_end;
  logic                       busy;
`ifdef MCDF_ARB_CH_MASK_EN
  logic [CH_NUM-1:0]          cfg_ch_en;
`endif

  mcdf_rd_arbiter #(
    .CH_NUM(CH_NUM), .FIFO_PTR_WIDE(3), .PKT_LEN(PKT_LEN), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_empty(ch_empty), .ch_level(ch_level), .ch_data(ch_data),
`ifdef MCDF_ARB_CH_MASK_EN
    .cfg_ch_en(cfg_ch_en),
`endif
    .ch_rd_en(ch_rd_en), .fmt_ready(fmt_ready), .fmt_valid(fmt_valid),
    .fmt_data(fmt_data), .fmt_ch_id(fmt_ch_id), .fmt_start(fmt_start),
    .fmt_end(fmt_end), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    checks   = 0;
  int    failures = 0;
  int    fill[CH_NUM];
  int    rd[CH_NUM];
  int    rd_pred[CH_NUM];
  beat_t sb[$];
  logic  gap_pending = 1'b0;

  logic              obs_valid, obs_busy, obs_start, obs_end;
  logic [DATA_W-1:0] obs_data;
  logic [2:0]        obs_ch;
  logic [CH_NUM-1:0] obs_rd;

  function automatic logic [31:0] mk(input int c, input int s);
    return 32'hA500_0000 | (32'(c) << 16) | 32'(s);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    int lvl;
    for (int c = 0; c < CH_NUM; c++) begin
      lvl = fill[c] - rd[c];
      ch_level[c*LVL_W +: LVL_W] = 4'(lvl);
      ch_empty[c]                = (lvl == 0);
      ch_data[c*DATA_W +: DATA_W] = mk(c, rd[c]);
    end
  endtask

  task automatic push_pkt(input int c);
    beat_t e;
    for (int b = 0; b < PKT_LEN; b++) begin
      e.ch   = 3'(c);
      e.data = mk(c, rd_pred[c]);
      e.st   = (b == 0);
      e.en   = (b == PKT_LEN - 1);
      sb.push_back(e);
      rd_pred[c]++;
    end
  endtask

  // Observe at the falling edge, apply FIFO pops just after the rising edge.
  task automatic cycle();
    beat_t e;
    logic  xf;
    @(negedge clk);
    obs_valid = fmt_valid; obs_busy = busy; obs_start = fmt_start; obs_end = fmt_end;
    obs_data  = fmt_data;  obs_ch   = fmt_ch_id; obs_rd = ch_rd_en;
    xf = fmt_valid && fmt_ready;
    if (sb.size() == 0) chk("unexpected_beat", 64'(xf), 64'd0);
    if (xf && sb.size() != 0) begin
      e = sb.pop_front();
      chk("beat_ch", 64'(fmt_ch_id), 64'(e.ch));
      chk("beat_data", 64'(fmt_data), 64'(e.data));
      chk("beat_start", 64'(fmt_start), 64'(e.st));
      chk("beat_end", 64'(fmt_end), 64'(e.en));
      chk("beat_rd_en", 64'(ch_rd_en), 64'(3'b001 << e.ch));
    end
    if (!xf) chk("no_xfer_rd_en", 64'(ch_rd_en), 64'd0);
    if (gap_pending) begin
      chk("gap_busy", 64'(busy), 64'd0);
      chk("gap_valid", 64'(fmt_valid), 64'd0);
    end
    gap_pending = xf && fmt_end;
    @(posedge clk);
    #1;
    for (int c = 0; c < CH_NUM; c++) if (obs_rd[c]) rd[c]++;
    drive();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int start_rd;
    rst = 1'b1;
    fmt_ready = 1'b1;
`ifdef MCDF_ARB_CH_MASK_EN
    cfg_ch_en = '1;
`endif
    for (int c = 0; c < CH_NUM; c++) begin
      fill[c] = 0; rd[c] = 0; rd_pred[c] = 0;
    end
    fill[0] = 8;
    drive();

    // Reset: outputs all zero even with an eligible channel present.
    repeat (3) begin
      cycle();
      chk("rst_valid", 64'(obs_valid), 64'd0);
      chk("rst_busy", 64'(obs_busy), 64'd0);
      chk("rst_data", 64'(obs_data), 64'd0);
      chk("rst_ch_id", 64'(obs_ch), 64'd0);
      chk("rst_start_end", 64'({obs_start, obs_end}), 64'd0);
    end
    fill[0] = rd[0];
    rst = 1'b0;
    drive();
    cycle();
    chk("post_rst_idle", 64'(obs_valid), 64'd0);

    // Single channel ch1 with exactly PKT_LEN words.
    fill[1] = rd[1] + 4;
    push_pkt(1);
    drive();
    cycle();
    chk("single_arb_cycle_valid", 64'(obs_valid), 64'd0);
    for (int b = 0; b < PKT_LEN; b++) begin
      cycle();
      chk("single_valid", 64'(obs_valid), 64'd1);
      chk("single_rd_en", 64'(obs_rd), 64'b010);
    end
    cycle();
    chk("single_done_valid", 64'(obs_valid), 64'd0);
    chk("single_pops", 64'(rd[1]), 64'd4);

    // Below threshold on ch2 (rr_ptr is now 2).
    fill[2] = rd[2] + 3;
    drive();
    repeat (8) begin
      cycle();
      chk("thr_valid", 64'(obs_valid), 64'd0);
      chk("thr_busy", 64'(obs_busy), 64'd0);
    end
    fill[2] = fill[2] + 1;
    push_pkt(2);
    drive();
    cycle();
    chk("thr_arb_idle", 64'(obs_valid), 64'd0);
    cycle();
    chk("thr_grant_valid", 64'(obs_valid), 64'd1);
    chk("thr_grant_ch", 64'(obs_ch), 64'd2);
    drain("thr_drain", 20);

    // Round robin from rr_ptr=0: 0,1,2,0,1,2.
    for (int c = 0; c < CH_NUM; c++) fill[c] = rd[c] + 8;
    push_pkt(0); push_pkt(1); push_pkt(2);
    push_pkt(0); push_pkt(1); push_pkt(2);
    drive();
    drain("rr_drain", 60);

    // Backpressure on beat 2 of a ch0 packet.
    fill[0] = rd[0] + 4;
    start_rd = rd[0];
    push_pkt(0);
    drive();
    cycle();
    cycle();
    cycle();
    fmt_ready = 1'b0;
    repeat (3) begin
      cycle();
      chk("bp_valid_held", 64'(obs_valid), 64'd1);
      chk("bp_data_held", 64'(obs_data), 64'(mk(0, start_rd + 2)));
      chk("bp_ch_held", 64'(obs_ch), 64'd0);
      chk("bp_start_end", 64'({obs_start, obs_end}), 64'd0);
    end
    fmt_ready = 1'b1;
    drain("bp_drain", 20);
    chk("bp_pops", 64'(rd[0] - start_rd), 64'd4);

    // Reset after beat 1 of a ch0 packet.
    fill[0] = rd[0] + 4;
    start_rd = rd[0];
    push_pkt(0);
    drive();
    cycle();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("abort_rst_valid", 64'(obs_valid), 64'd0);
    chk("abort_rst_rd_en", 64'(obs_rd), 64'd0);
    rst = 1'b0;
    sb.delete();
    gap_pending = 1'b0;
    for (int c = 0; c < CH_NUM; c++) rd_pred[c] = rd[c];
    cycle();
    chk("abort_valid", 64'(obs_valid), 64'd0);
    chk("abort_busy", 64'(obs_busy), 64'd0);
    chk("abort_rd_en", 64'(obs_rd), 64'd0);
    chk("abort_pops", 64'(rd[0] - start_rd), 64'd2);
    for (int c = 0; c < CH_NUM; c++) fill[c] = fill[c] + 4;
    push_pkt(0); push_pkt(1); push_pkt(2);
    drive();
    drain("abort_rr_drain", 40);

`ifdef MCDF_ARB_CH_MASK_EN
    // Masked ch1: grants alternate 0,2 and ch1 is never popped.
    cfg_ch_en = 3'b101;
    start_rd = rd[1];
    for (int c = 0; c < CH_NUM; c++) fill[c] = rd[c] + 8;
    push_pkt(0); push_pkt(2); push_pkt(0); push_pkt(2);
    drive();
    drain("mask_drain", 60);
    repeat (4) cycle();
    chk("mask_ch1_pops", 64'(rd[1] - start_rd), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcdf_rd_arbiter.md
Name: mcdf_rd_arbiter

Overview:
- Round-robin read arbiter for the MCDF channel FIFOs.
- Shares the single formatter input port between CH_NUM first-word-fall-through channel FIFOs. Each FIFO has its own read-address generator.
- Grants one channel at a time for a fixed-length packet of PKT_LEN words and drives that channel's rd_en.
- Sits between the per-channel FIFOs (empty flag, fill level, head data) and the packet formatter (valid/ready).

Parameters:
- CH_NUM, 3, number of requesting channels (2..8).
- FIFO_PTR_WIDE, 3, channel FIFO pointer width; FIFO depth = 2**FIFO_PTR_WIDE; level width LVL_W = FIFO_PTR_WIDE+1.
- PKT_LEN, 4, words per granted packet (1..2**FIFO_PTR_WIDE).
- DATA_W, 32, data word width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset: synchronous and active-high.
- ch_empty  in  CH_NUM  per-channel FIFO empty flag.
- ch_level  in  CH_NUM*LVL_W  per-channel fill level, channel i at bits [i*LVL_W +: LVL_W].
- ch_data  in  CH_NUM*DATA_W  per-channel FWFT head word, channel i at [i*DATA_W +: DATA_W].
- ch_rd_en  out  CH_NUM  one-hot pop strobe to the granted channel's FIFO.
- fmt_ready  in  1  formatter accepts a word this cycle.
- fmt_valid  out  1  word on fmt_data is valid.
- fmt_data  out  DATA_W  granted channel head word.
- fmt_ch_id  out  3  granted channel index.
- fmt_start  out  1  first beat of packet, qualified by fmt_valid.
- fmt_end  out  1  last beat of packet, qualified by fmt_valid.
- busy  out  1  packet in progress (state SEND).

Behaviour:

Registered state:
- state {IDLE, SEND}, gnt (3b), rr_ptr (3b), beat_cnt (LVL_W b).
- Reset values: state=IDLE, gnt=0, rr_ptr=0, beat_cnt=0.
- During reset all outputs are 0, fmt_data included.

Eligibility and arbitration:
- elig[i] = (ch_level[i] >= PKT_LEN).
- IDLE: scan channels rr_ptr, rr_ptr+1, ... mod CH_NUM. The first eligible channel wins.
- On a win: gnt<=winner, rr_ptr<=(winner+1) mod CH_NUM, beat_cnt<=0, state<=SEND.
- No eligible channel: stay in IDLE with rr_ptr unchanged.
- Latency: eligibility sampled at edge t gives fmt_valid=1 from cycle t+1.

SEND outputs:
- fmt_valid = !ch_empty[gnt].
- fmt_data = ch_data[gnt].
- fmt_ch_id = gnt.
- fmt_start = fmt_valid && beat_cnt==0.
- fmt_end = fmt_valid && beat_cnt==PKT_LEN-1.

Handshake:
- A beat transfers when fmt_valid && fmt_ready.
- ch_rd_en[gnt]=1 only on a transferred beat. All other ch_rd_en bits are always 0. In IDLE every ch_rd_en bit is 0.
- fmt_ready=0 stalls the packet: fmt_data, fmt_ch_id, beat_cnt and fmt_valid are held; no pop.
- Transferred beat with beat_cnt<PKT_LEN-1: beat_cnt++.
- Transferred beat with beat_cnt==PKT_LEN-1: state<=IDLE, beat_cnt<=0.

Boundary conditions:
- Packets never interleave. There is at least one IDLE (arbitration) cycle between packets, giving 1-cycle minimum gap.
- PKT_LEN=1: fmt_start and fmt_end assert on the same beat.
- ch_empty[gnt] asserting in SEND is an upstream fault. fmt_valid drops, nothing is popped, and state is held until data reappears.
- rr_ptr wrap: for winner CH_NUM-1, the next scan starts at 0.
- rst asserted mid-packet: abort. Next cycle is IDLE with all outputs 0; the aborted beats are not replayed.
- IDLE outputs: fmt_valid, fmt_start, fmt_end and busy are 0. fmt_data and fmt_ch_id reflect gnt but are don't-care.

Optional Feature:
- Macro: MCDF_ARB_CH_MASK_EN.
- Defined: adds input port cfg_ch_en [CH_NUM], and elig[i] additionally requires cfg_ch_en[i].
  - Clearing a bit during SEND does not abort the current packet. It only blocks future grants.
- Undefined: no cfg_ch_en port; all channels are always enabled.

Test Plan:
- Single channel: ch_level[1]=4, others 0, fmt_ready=1.
  - Expect fmt_valid for 4 consecutive cycles starting 1 cycle after arbitration, fmt_ch_id=1.
  - Expect fmt_start on beat 0, fmt_end on beat 3, and ch_rd_en=3'b010 on each beat.
- Round-robin: all three levels=8, fmt_ready=1.
  - Expect grant order 0,1,2,0 with a 1-cycle IDLE gap between packets; rr_ptr wraps to 0 after channel 2.
- Backpressure: grant ch0, fmt_ready held low on beat 2 for 3 cycles.
  - fmt_data and beat_cnt are held, ch_rd_en=0 during the stall.
  - The packet completes with exactly 4 pops total.
- Below threshold: ch_level[2]=3, others 0.
  - Expect no grant and ch_rd_en=0 indefinitely.
  - Raise the level to 4: expect a grant to ch2 on the next cycle.
- Reset mid-packet: assert rst after beat 1 of a ch0 packet.
  - Next cycle: fmt_valid=0, busy=0, ch_rd_en=0.
  - After release, arbitration restarts from rr_ptr=0.
- With MCDF_ARB_CH_MASK_EN: cfg_ch_en=3'b101, all levels=8.
  - Grant order 0,2,0,2; ch1 is never popped.
